// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One bit of CRC-16-CCITT, register held MSB-first.
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host word stream handshake between the configuration port and the loader.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_data, output word_valid, input word_ready);
    modport slave  (input word_data, input word_valid, output word_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with enable and synchronous clear.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_r;

    // CRC register: reset/clear to init, fold one bit per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_r <= CRC16_INIT;
        end else if (clr) begin
            crc_r <= CRC16_INIT;
        end else if (en) begin
            crc_r <= crc16_update(crc_r, bit_in);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises host words onto ccff_head for a full configuration-chain load.
// Optional CRC over the shifted bits is enabled with macro CCFF_LOADER_CRC_EN.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 2048,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    start,
    ccff_bitstream_loader_if.slave  word_bus,
    output logic                    ccff_head,
    output logic                    ccff_shift_en,
    output logic                    config_enable,
    output logic                    busy,
    output logic                    done
`ifdef CCFF_LOADER_CRC_EN
    ,
    input  logic [15:0]             crc_expect,
    output logic [15:0]             crc_out,
    output logic                    crc_ok
`endif
);

    localparam int                IDX_W     = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CHAIN_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t              state_r, state_s;
    logic [WORD_W-1:0]   shreg_r, shreg_s;
    logic [IDX_W-1:0]    bit_idx_r, bit_idx_s;
    logic [CNT_W-1:0]    bits_left_r, bits_left_s;
    logic                accept_s, load_start_s;

    logic word_ready_r, head_r, shift_en_r, busy_r, done_r;
    logic word_ready_s, head_s, shift_en_s, busy_s, done_s;

    // word_ready_r is the ready currently presented to the host.
    assign accept_s = word_ready_r & word_bus.word_valid;

    // Next-state, shift register and counter update.
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        bit_idx_s    = bit_idx_r;
        bits_left_s  = bits_left_r;
        load_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s      = FETCH;
                    bits_left_s  = CHAIN_CNT;
                    load_start_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (accept_s) begin
                    shreg_s   = word_bus.word_data;
                    bit_idx_s = {IDX_W{1'b0}};
                    state_s   = SHIFT;
                end else begin
                    state_s = FETCH;
                end
            end
            SHIFT: begin
                bits_left_s = bits_left_r - CNT_ONE;
                shreg_s     = shreg_r >> 1;
                bit_idx_s   = bit_idx_r + IDX_W'(1);
                // Leftover upper bits of a partial final word are simply dropped.
                if (bits_left_r == CNT_ONE) begin
                    state_s = DONE;
                end else if (bit_idx_r == LAST_IDX) begin
                    if (accept_s) begin
                        shreg_s   = word_bus.word_data;
                        bit_idx_s = {IDX_W{1'b0}};
                        state_s   = SHIFT;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from next-state values so every output leaves a flop.
    always_comb begin
        word_ready_s = 1'b0;
        head_s       = 1'b0;
        shift_en_s   = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        case (state_s)
            IDLE: begin
                word_ready_s = 1'b0;
            end
            FETCH: begin
                word_ready_s = 1'b1;
                busy_s       = 1'b1;
            end
            SHIFT: begin
                head_s       = shreg_s[0];
                shift_en_s   = 1'b1;
                busy_s       = 1'b1;
                word_ready_s = (bit_idx_s == LAST_IDX) && (bits_left_s > CNT_ONE);
            end
            DONE: begin
                done_s = 1'b1;
            end
            default: begin
                word_ready_s = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_r      <= IDLE;
            shreg_r      <= {WORD_W{1'b0}};
            bit_idx_r    <= {IDX_W{1'b0}};
            bits_left_r  <= {CNT_W{1'b0}};
            word_ready_r <= 1'b0;
            head_r       <= 1'b0;
            shift_en_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            bit_idx_r    <= bit_idx_s;
            bits_left_r  <= bits_left_s;
            word_ready_r <= word_ready_s;
            head_r       <= head_s;
            shift_en_r   <= shift_en_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign word_bus.word_ready = word_ready_r;
    assign ccff_head           = head_r;
    assign ccff_shift_en       = shift_en_r;
    assign config_enable       = busy_r;
    assign busy                = busy_r;
    assign done                = done_r;

`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc_r;
    logic        crc_ok_r;
    logic        crc_en_s;

    assign crc_en_s = (state_r == SHIFT);

    ccff_crc16_serial u_crc (
        .clk    (prog_clk),
        .rst    (pReset),
        .clr    (load_start_s),
        .en     (crc_en_s),
        .bit_in (shreg_r[0]),
        .crc    (crc_r)
    );

    // Verdict includes the final bit so it is ready in the done cycle.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            crc_ok_r <= 1'b0;
        end else if (load_start_s) begin
            crc_ok_r <= 1'b0;
        end else if ((state_r == SHIFT) && (state_s == DONE)) begin
            crc_ok_r <= (crc16_update(crc_r, shreg_r[0]) == crc_expect);
        end else begin
            crc_ok_r <= crc_ok_r;
        end
    end

    assign crc_out = crc_r;
    assign crc_ok  = crc_ok_r;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader with WORD_W=8, CHAIN_LEN=20.
module tb_ccff_bitstream_loader;

    localparam int WORD_W    = 8;
    localparam int CHAIN_LEN = 20;

    logic clk = 1'b0;
    logic pReset;
    logic start;
    logic ccff_head, ccff_shift_en, config_enable, busy, done;
`ifdef CCFF_LOADER_CRC_EN
    logic [15:0] crc_expect;
    logic [15:0] crc_out;
    logic        crc_ok;
    logic        crc_ok_done;
    logic [15:0] crc_out_done;
`endif

    always #5 clk = ~clk;

    ccff_bitstream_loader_if #(.WORD_W(WORD_W)) bus ();

    ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk      (clk),
        .pReset        (pReset),
        .start         (start),
        .word_bus      (bus),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .config_enable (config_enable),
        .busy          (busy),
        .done          (done)
`ifdef CCFF_LOADER_CRC_EN
        ,
        .crc_expect    (crc_expect),
        .crc_out       (crc_out),
        .crc_ok        (crc_ok)
`endif
    );

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic exp_q[$];
    int   to_push;
    int   shift_cnt, done_cnt, run_cur, run_max;
    logic cfg_at_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every shift cycle pops one expected chain bit.
    always @(negedge clk) begin
        if (ccff_shift_en === 1'b1) begin
            shift_cnt++;
            run_cur++;
            if (run_cur > run_max) run_max = run_cur;
            if (exp_q.size() == 0) check_eq("extra_shift", {31'd0, ccff_shift_en}, 32'd0);
            else                   check_eq("head_bit", {31'd0, ccff_head}, {31'd0, exp_q.pop_front()});
        end else begin
            run_cur = 0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            cfg_at_done = config_enable;
`ifdef CCFF_LOADER_CRC_EN
            crc_ok_done  = crc_ok;
            crc_out_done = crc_out;
`endif
        end
    end

    task automatic send_word(input logic [7:0] d, output int waits);
        int n;
        n = 0;
        bus.word_data  = d;
        bus.word_valid = 1'b1;
        while (bus.word_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (bus.word_ready !== 1'b1) begin
            check_eq("ready_timeout", {31'd0, bus.word_ready}, 32'd1);
        end else begin
            for (int i = 0; i < WORD_W; i++) begin
                if (to_push > 0) begin
                    exp_q.push_back(d[i]);
                    to_push--;
                end
            end
        end
        waits = n;
        @(negedge clk);
    endtask

    task automatic begin_load();
        exp_q.delete();
        to_push   = CHAIN_LEN;
        shift_cnt = 0;
        done_cnt  = 0;
        run_cur   = 0;
        run_max   = 0;
        cfg_at_done = 1'b1;
    endtask

    task automatic run_load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                            input bit stall, input bit mid_start, input int exp_run);
        int waits, n;
        begin_load();
        bus.word_data  = w0;
        bus.word_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(w0, waits);
        check_eq("first_accept_wait", waits, 32'd0);
        if (mid_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (stall) begin
            bus.word_valid = 1'b0;
            repeat (8) @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                check_eq("stall_shift_en", {31'd0, ccff_shift_en}, 32'd0);
                check_eq("stall_cfg_en", {31'd0, config_enable}, 32'd1);
                @(negedge clk);
            end
        end
        send_word(w1, waits);
        send_word(w2, waits);
        bus.word_valid = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", done_cnt, 32'd1);
        repeat (2) @(negedge clk);
        check_eq("shift_count", shift_cnt, CHAIN_LEN);
        check_eq("done_count", done_cnt, 32'd1);
        check_eq("bits_left_in_q", exp_q.size(), 32'd0);
        check_eq("cfg_in_done", {31'd0, cfg_at_done}, 32'd0);
        check_eq("cfg_after", {31'd0, config_enable}, 32'd0);
        check_eq("busy_after", {31'd0, busy}, 32'd0);
        check_eq("longest_run", run_max, exp_run);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, {31'd0, bus.word_ready}, 32'd0);
        check_eq({tag, "_head"}, {31'd0, ccff_head}, 32'd0);
        check_eq({tag, "_shift_en"}, {31'd0, ccff_shift_en}, 32'd0);
        check_eq({tag, "_cfg"}, {31'd0, config_enable}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

`ifdef CCFF_LOADER_CRC_EN
    function automatic logic [15:0] golden_crc_ones(input int nbits);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < nbits; i++) begin
            if (c[15] ^ 1'b1) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    initial begin
        int waits, n;
        pReset         = 1'b1;
        start          = 1'b0;
        bus.word_data  = 8'h00;
        bus.word_valid = 1'b0;
`ifdef CCFF_LOADER_CRC_EN
        crc_expect = 16'h0000;
`endif
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        pReset = 1'b0;
        @(negedge clk);

        // Basic load, valid held high throughout: one unbroken 20-cycle run.
        run_load(8'hA5, 8'h3C, 8'h0F, 1'b0, 1'b0, CHAIN_LEN);
        // Host stalls after the first word: 8-bit run, gap, then 12-bit run.
        run_load(8'hA5, 8'h3C, 8'h0F, 1'b1, 1'b0, 12);
        // Start pulsed mid-load must not restart anything.
        run_load(8'h5A, 8'hC3, 8'hF6, 1'b0, 1'b1, CHAIN_LEN);

        // Reset around the seventh shift, then a full reload.
        begin_load();
        bus.word_data  = 8'hA5;
        bus.word_valid = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_word(8'hA5, waits);
        bus.word_valid = 1'b0;
        n = 0;
        while (shift_cnt < 7 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_shift7", {31'd0, shift_cnt >= 7}, 32'd1);
        pReset = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        pReset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        run_load(8'h96, 8'h69, 8'h0A, 1'b0, 1'b0, CHAIN_LEN);

`ifdef CCFF_LOADER_CRC_EN
        crc_expect = golden_crc_ones(CHAIN_LEN);
        run_load(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, CHAIN_LEN);
        check_eq("crc_out_done", {16'd0, crc_out_done}, {16'd0, golden_crc_ones(CHAIN_LEN)});
        check_eq("crc_ok_match", {31'd0, crc_ok_done}, 32'd1);
        check_eq("crc_ok_hold", {31'd0, crc_ok}, 32'd1);
        crc_expect = golden_crc_ones(CHAIN_LEN) ^ 16'h0001;
        run_load(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, CHAIN_LEN);
        check_eq("crc_ok_flipped", {31'd0, crc_ok_done}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
